// File: rtl/vend_ctrl.sv
// vend_ctrl: coin-credit vending controller.
// Collects coins in half-unit steps, charges the selected product's price,
// hands off to the dispenser via req/ack, then pays change one coin per
// hopper handshake using the largest coin that fits.
module vend_ctrl #(
    parameter int PRICE0     = 3,
    parameter int PRICE1     = 4,
    parameter int PRICE2     = 5,
    parameter int PRICE3     = 6,
    parameter int MAX_CREDIT = 16,
    parameter int TIMEOUT    = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       d1,
    input  logic       d2,
    input  logic       d3,
    input  logic       sel_valid,
    input  logic [1:0] sel,
    input  logic       cancel,
    input  logic       vend_ack,
    input  logic       chg_ready,
    output logic       vend_req,
    output logic [1:0] vend_id,
    output logic       chg_valid,
    output logic [1:0] chg_coin,
    output logic [4:0] credit,
    output logic       busy,
    output logic       coin_reject
);

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    state_t     state, state_nx;
    logic [4:0] credit_nx;
    logic [1:0] vend_id_nx;
    logic [7:0] tcnt, tcnt_nx;
    logic       reject_nx;

    logic [2:0] coin_val;
    logic       coin_any, coin_extra, coin_ok;
    logic [5:0] sum;
    logic [4:0] eff, price_sel, chg_amt;

    // Coin decode: one coin per cycle, d1 beats d2 beats d3; losers are refused.
    always_comb begin
        coin_val   = 3'd0;
        coin_extra = 1'b0;
        if (d1) begin
            coin_val   = 3'd1;
            coin_extra = d2 | d3;
        end else if (d2) begin
            coin_val   = 3'd2;
            coin_extra = d3;
        end else if (d3) begin
            coin_val   = 3'd4;
        end
    end

    assign coin_any = d1 | d2 | d3;
    assign sum      = {1'b0, credit} + {3'b000, coin_val};
    assign coin_ok  = coin_any && (state == IDLE || state == COLLECT) &&
                      (sum <= 6'(MAX_CREDIT));
    // Credit after this cycle's coin; the selection and cancel act on this value.
    assign eff      = coin_ok ? sum[4:0] : credit;

    // Price lookup for the current selection.
    always_comb begin
        case (sel)
            2'd0:    price_sel = 5'(PRICE0);
            2'd1:    price_sel = 5'(PRICE1);
            2'd2:    price_sel = 5'(PRICE2);
            default: price_sel = 5'(PRICE3);
        endcase
    end

    // Largest change coin that fits the remaining credit.
    always_comb begin
        if (credit >= 5'd4) begin
            chg_amt  = 5'd4;
            chg_coin = (state == CHANGE) ? 2'b11 : 2'b00;
        end else if (credit >= 5'd2) begin
            chg_amt  = 5'd2;
            chg_coin = (state == CHANGE) ? 2'b10 : 2'b00;
        end else begin
            chg_amt  = 5'd1;
            chg_coin = (state == CHANGE) ? 2'b01 : 2'b00;
        end
    end

    // Next-state, credit, timeout and reject logic.
    always_comb begin
        state_nx   = state;
        credit_nx  = credit;
        vend_id_nx = vend_id;
        tcnt_nx    = tcnt;
        reject_nx  = coin_extra | (coin_any & ~coin_ok);
        case (state)
            IDLE: begin
                if (coin_ok) begin
                    credit_nx = eff;
                    state_nx  = COLLECT;
                    tcnt_nx   = 8'd0;
                end
            end
            COLLECT: begin
                credit_nx = eff;
                if (cancel) begin
                    tcnt_nx  = 8'd0;
                    state_nx = (eff == 5'd0) ? IDLE : CHANGE;
                end else if (sel_valid && eff >= price_sel) begin
                    state_nx   = VEND;
                    credit_nx  = eff - price_sel;
                    vend_id_nx = sel;
                    tcnt_nx    = 8'd0;
                end else if (coin_ok || sel_valid) begin
                    tcnt_nx = 8'd0;
                end else if (tcnt == 8'(TIMEOUT - 1)) begin
                    state_nx = CHANGE;
                    tcnt_nx  = 8'd0;
                end else begin
                    tcnt_nx = tcnt + 8'd1;
                end
            end
            VEND: begin
                if (vend_ack)
                    state_nx = (credit != 5'd0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                if (chg_ready) begin
                    credit_nx = credit - chg_amt;
                    if (credit == chg_amt)
                        state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any held credit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            credit      <= 5'd0;
            vend_id     <= 2'd0;
            tcnt        <= 8'd0;
            coin_reject <= 1'b0;
        end else begin
            state       <= state_nx;
            credit      <= credit_nx;
            vend_id     <= vend_id_nx;
            tcnt        <= tcnt_nx;
            coin_reject <= reject_nx;
        end
    end

    assign vend_req  = (state == VEND);
    assign chg_valid = (state == CHANGE);
    assign busy      = (state == VEND) || (state == CHANGE);

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl: hand-computed expectations per scenario.
module tb_vend_ctrl;
    localparam int TIMEOUT = 200;

    logic       clk = 1'b0;
    logic       rst, d1, d2, d3, sel_valid, cancel, vend_ack, chg_ready;
    logic [1:0] sel;
    logic       vend_req, chg_valid, busy, coin_reject;
    logic [1:0] vend_id, chg_coin;
    logic [4:0] credit;

    int nvec = 0;
    int nerr = 0;

    vend_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .d1(d1), .d2(d2), .d3(d3),
        .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
        .vend_ack(vend_ack), .chg_ready(chg_ready),
        .vend_req(vend_req), .vend_id(vend_id), .chg_valid(chg_valid),
        .chg_coin(chg_coin), .credit(credit), .busy(busy),
        .coin_reject(coin_reject)
    );

    always #5 clk = ~clk;

    // One clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        d1 = 0; d2 = 0; d3 = 0; sel_valid = 0; sel = 0;
        cancel = 0; vend_ack = 0; chg_ready = 0;
    endtask

    task automatic test_reset();
        clear_in();
        rst = 1; cyc(); cyc();
        nvec++; if (credit !== 5'd0) begin $display("FAIL reset_credit got %0d want 0", credit); nerr++; end
        nvec++; if ({vend_req, chg_valid, busy, coin_reject} !== 4'b0000) begin $display("FAIL reset_flags got %b want 0000", {vend_req, chg_valid, busy, coin_reject}); nerr++; end
        nvec++; if ({vend_id, chg_coin} !== 4'b0000) begin $display("FAIL reset_codes got %b want 0000", {vend_id, chg_coin}); nerr++; end
        rst = 0;
    endtask

    task automatic test_exact_vend();
        d1 = 1; cyc(); d1 = 0;
        nvec++; if (credit !== 5'd1) begin $display("FAIL ev_d1 credit got %0d want 1", credit); nerr++; end
        d2 = 1; cyc(); d2 = 0;
        nvec++; if (credit !== 5'd3) begin $display("FAIL ev_d2 credit got %0d want 3", credit); nerr++; end
        sel_valid = 1; sel = 2'd0; cyc(); sel_valid = 0;
        nvec++; if ({vend_req, vend_id, busy} !== 4'b1001) begin $display("FAIL ev_req got %b want 1001", {vend_req, vend_id, busy}); nerr++; end
        nvec++; if (credit !== 5'd0) begin $display("FAIL ev_credit got %0d want 0", credit); nerr++; end
        cyc();
        nvec++; if (vend_req !== 1'b1) begin $display("FAIL ev_hold got %b want 1", vend_req); nerr++; end
        vend_ack = 1; cyc(); vend_ack = 0;
        nvec++; if ({vend_req, chg_valid, busy} !== 3'b000) begin $display("FAIL ev_done got %b want 000", {vend_req, chg_valid, busy}); nerr++; end
    endtask

    task automatic test_vend_change();
        d3 = 1; cyc(); d3 = 0;
        nvec++; if (credit !== 5'd4) begin $display("FAIL vc_d3 credit got %0d want 4", credit); nerr++; end
        sel_valid = 1; sel = 2'd0; cyc(); sel_valid = 0;
        nvec++; if ({vend_req, credit} !== {1'b1, 5'd1}) begin $display("FAIL vc_vend got %b want 1_00001", {vend_req, credit}); nerr++; end
        vend_ack = 1; cyc(); vend_ack = 0;
        nvec++; if ({chg_valid, chg_coin, vend_req} !== 4'b1010) begin $display("FAIL vc_chg got %b want 1010", {chg_valid, chg_coin, vend_req}); nerr++; end
        cyc();
        nvec++; if ({chg_valid, chg_coin, credit} !== {3'b101, 5'd1}) begin $display("FAIL vc_hold got %b want 101_00001", {chg_valid, chg_coin, credit}); nerr++; end
        chg_ready = 1; cyc(); chg_ready = 0;
        nvec++; if ({chg_valid, chg_coin, busy, credit} !== 9'd0) begin $display("FAIL vc_done got %b want 0", {chg_valid, chg_coin, busy, credit}); nerr++; end
    endtask

    task automatic test_overflow_refund();
        logic [4:0] exp_cr;
        for (int i = 1; i <= 4; i++) begin
            d3 = 1; cyc(); d3 = 0;
            exp_cr = 5'(4 * i);
            nvec++; if (credit !== exp_cr) begin $display("FAIL ov_fill%0d credit got %0d want %0d", i, credit, exp_cr); nerr++; end
        end
        d1 = 1; cyc(); d1 = 0;
        nvec++; if ({coin_reject, credit} !== {1'b1, 5'd16}) begin $display("FAIL ov_reject got %b want 1_10000", {coin_reject, credit}); nerr++; end
        cyc();
        nvec++; if (coin_reject !== 1'b0) begin $display("FAIL ov_pulse got %b want 0", coin_reject); nerr++; end
        cancel = 1; cyc(); cancel = 0;
        nvec++; if ({chg_valid, chg_coin, credit} !== {3'b111, 5'd16}) begin $display("FAIL ov_cancel got %b want 111_10000", {chg_valid, chg_coin, credit}); nerr++; end
        chg_ready = 1;
        for (int i = 3; i >= 0; i--) begin
            cyc();
            exp_cr = 5'(4 * i);
            nvec++; if (credit !== exp_cr) begin $display("FAIL ov_pay%0d credit got %0d want %0d", i, credit, exp_cr); nerr++; end
        end
        chg_ready = 0;
        nvec++; if ({chg_valid, busy} !== 2'b00) begin $display("FAIL ov_idle got %b want 00", {chg_valid, busy}); nerr++; end
    endtask

    task automatic test_insufficient();
        d2 = 1; cyc(); d2 = 0;
        sel_valid = 1; sel = 2'd1; cyc(); sel_valid = 0;
        nvec++; if ({vend_req, credit} !== {1'b0, 5'd2}) begin $display("FAIL in_short got %b want 0_00010", {vend_req, credit}); nerr++; end
        d2 = 1; sel_valid = 1; sel = 2'd1; cyc(); d2 = 0; sel_valid = 0;
        nvec++; if ({vend_req, vend_id, credit} !== {3'b101, 5'd0}) begin $display("FAIL in_same got %b want 101_00000", {vend_req, vend_id, credit}); nerr++; end
        vend_ack = 1; cyc(); vend_ack = 0;
        nvec++; if (busy !== 1'b0) begin $display("FAIL in_done busy got %b want 0", busy); nerr++; end
    endtask

    task automatic test_priority_idle();
        // IDLE ignores selection and ack
        sel_valid = 1; sel = 2'd0; vend_ack = 1; cyc(); sel_valid = 0; vend_ack = 0;
        nvec++; if ({vend_req, busy, credit} !== 7'd0) begin $display("FAIL pi_idle got %b want 0", {vend_req, busy, credit}); nerr++; end
        d1 = 1; d3 = 1; cyc(); d1 = 0; d3 = 0;
        nvec++; if ({coin_reject, credit} !== {1'b1, 5'd1}) begin $display("FAIL pi_prio got %b want 1_00001", {coin_reject, credit}); nerr++; end
        cancel = 1; cyc(); cancel = 0;
        nvec++; if ({chg_valid, chg_coin} !== 3'b101) begin $display("FAIL pi_cancel got %b want 101", {chg_valid, chg_coin}); nerr++; end
        chg_ready = 1; cyc(); chg_ready = 0;
        nvec++; if ({chg_valid, credit} !== 6'd0) begin $display("FAIL pi_done got %b want 0", {chg_valid, credit}); nerr++; end
    endtask

    task automatic test_timeout();
        d2 = 1; cyc(); d2 = 0;
        repeat (TIMEOUT - 1) cyc();
        nvec++; if ({chg_valid, credit} !== {1'b0, 5'd2}) begin $display("FAIL to_early got %b want 0_00010", {chg_valid, credit}); nerr++; end
        cyc();
        nvec++; if ({chg_valid, chg_coin} !== 3'b110) begin $display("FAIL to_fire got %b want 110", {chg_valid, chg_coin}); nerr++; end
        chg_ready = 1; cyc(); chg_ready = 0;
        nvec++; if ({chg_valid, busy, credit} !== 7'd0) begin $display("FAIL to_done got %b want 0", {chg_valid, busy, credit}); nerr++; end
    endtask

    task automatic test_reset_busy();
        d3 = 1; cyc(); d3 = 0;
        cancel = 1; cyc(); cancel = 0;
        nvec++; if (chg_valid !== 1'b1) begin $display("FAIL rb_chg got %b want 1", chg_valid); nerr++; end
        rst = 1; cyc(); rst = 0;
        nvec++; if ({chg_valid, busy, credit} !== 7'd0) begin $display("FAIL rb_rst got %b want 0", {chg_valid, busy, credit}); nerr++; end
        d3 = 1; cyc(); d3 = 0;
        sel_valid = 1; sel = 2'd0; cyc(); sel_valid = 0;
        d3 = 1; cyc(); d3 = 0;
        nvec++; if ({vend_req, coin_reject, credit} !== {2'b11, 5'd1}) begin $display("FAIL rb_vendcoin got %b want 11_00001", {vend_req, coin_reject, credit}); nerr++; end
        vend_ack = 1; cyc(); vend_ack = 0;
        chg_ready = 1; cyc(); chg_ready = 0;
        nvec++; if ({busy, credit} !== 6'd0) begin $display("FAIL rb_done got %b want 0", {busy, credit}); nerr++; end
    endtask

    initial begin
        test_reset();
        test_exact_vend();
        test_vend_change();
        test_overflow_refund();
        test_insufficient();
        test_priority_idle();
        test_timeout();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
